// File: rtl/pv_scheduler.sv
// rtl/pv_scheduler.sv - PV+ inhibition scheduler sharing one leaky integrator across L2/3, L4 and L5.
// Optional macro PV_L5_FEEDBACK_EN enables the L5 update step and its term in the total.
module pv_scheduler #(
  parameter int WIDTH     = 18,
  parameter int FRAC      = 14,
  parameter int TAU_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] pyr_l23,
  input  logic signed [WIDTH-1:0] pyr_l4,
  input  logic signed [WIDTH-1:0] pyr_l5b,
  output logic signed [WIDTH-1:0] pv_l23_inhibition,
  output logic signed [WIDTH-1:0] pv_l4_inhibition,
  output logic signed [WIDTH-1:0] pv_l5_inhibition,
  output logic signed [WIDTH-1:0] pv_total_inhibition,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  if (FRAC >= WIDTH) begin : g_frac_check
    $error("FRAC must be smaller than WIDTH");
  end

  typedef enum logic [2:0] {IDLE, UPD_L23, UPD_L4, UPD_L5, SUM} state_t;

  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_next;
  logic signed [WIDTH-1:0] lat_l23, lat_l4, lat_l5;
  logic signed [WIDTH-1:0] sel_drive, sel_pv, pv_next, total_next;
  logic signed [WIDTH-1:0] half_l4, quarter_l5;
  logic signed [WIDTH:0]   diff, step, acc;
  logic signed [WIDTH+1:0] tsum;

  // |x| with the most-negative code folded onto the largest positive value
  function automatic logic signed [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
    if (x == MIN_NEG)   abs_sat = MAX_POS;
    else if (x[WIDTH-1]) abs_sat = -x;
    else                 abs_sat = x;
  endfunction

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clk_en) state_next = UPD_L23;
      UPD_L23: state_next = UPD_L4;
`ifdef PV_L5_FEEDBACK_EN
      UPD_L4:  state_next = UPD_L5;
`else
      UPD_L4:  state_next = SUM;
`endif
      UPD_L5:  state_next = SUM;
      SUM:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shared integrator: operands are selected by the population being updated
  always_comb begin
    sel_drive = '0;
    sel_pv    = '0;
    case (state)
      UPD_L23: begin sel_drive = abs_sat(lat_l23); sel_pv = pv_l23_inhibition; end
      UPD_L4:  begin sel_drive = abs_sat(lat_l4);  sel_pv = pv_l4_inhibition;  end
      UPD_L5:  begin sel_drive = abs_sat(lat_l5);  sel_pv = pv_l5_inhibition;  end
      default: begin sel_drive = '0;               sel_pv = '0;                end
    endcase
    diff = {sel_drive[WIDTH-1], sel_drive} - {sel_pv[WIDTH-1], sel_pv};
    step = diff >>> TAU_SHIFT;
    acc  = {sel_pv[WIDTH-1], sel_pv} + step;
    if (acc[WIDTH])        pv_next = '0;
    else if (acc[WIDTH-1]) pv_next = MAX_POS;
    else                   pv_next = acc[WIDTH-1:0];
  end

  always_comb begin
    half_l4    = pv_l4_inhibition >>> 1;
    quarter_l5 = pv_l5_inhibition >>> 2;
    tsum = {{2{pv_l23_inhibition[WIDTH-1]}}, pv_l23_inhibition}
         + {{2{half_l4[WIDTH-1]}}, half_l4};
`ifdef PV_L5_FEEDBACK_EN
    tsum = tsum + {{2{quarter_l5[WIDTH-1]}}, quarter_l5};
`endif
    if (tsum[WIDTH+1])                total_next = '0;
    else if (|tsum[WIDTH:WIDTH-1])    total_next = MAX_POS;
    else                              total_next = tsum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      lat_l23             <= '0;
      lat_l4              <= '0;
      lat_l5              <= '0;
      pv_l23_inhibition   <= '0;
      pv_l4_inhibition    <= '0;
      pv_l5_inhibition    <= '0;
      pv_total_inhibition <= '0;
      done                <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == SUM);
      if (clk_en && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (clk_en) begin
          lat_l23 <= pyr_l23;
          lat_l4  <= pyr_l4;
          lat_l5  <= pyr_l5b;
        end
        UPD_L23: pv_l23_inhibition   <= pv_next;
        UPD_L4:  pv_l4_inhibition    <= pv_next;
        UPD_L5:  pv_l5_inhibition    <= pv_next;
        SUM:     pv_total_inhibition <= total_next;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pv_scheduler.md
PV_SCHEDULER -- requirements
Module: pv_scheduler

Interface
REQ-001 Parameter WIDTH, default 18, signed fixed-point word width.
REQ-002 Parameter FRAC, default 14, fractional bits (1.0 = 16384).
REQ-003 Parameter TAU_SHIFT, default 3, leak shift of the PV+ integrator.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 clk_en  in  1  update tick; requests one full PV+ update round.
REQ-007 pyr_l23  in  WIDTH signed  L2/3 pyramidal drive.
REQ-008 pyr_l4  in  WIDTH signed  L4 pyramidal drive.
REQ-009 pyr_l5b  in  WIDTH signed  L5b pyramidal drive.
REQ-010 pv_l23_inhibition / pv_l4_inhibition / pv_l5_inhibition  out  WIDTH signed  per-population PV+ state, range 0..2^(WIDTH-1)-1.
REQ-011 pv_total_inhibition  out  WIDTH signed  weighted cross-layer sum.
REQ-012 busy  out  1  high whenever the FSM is not IDLE.
REQ-013 done  out  1  one-cycle pulse when pv_total_inhibition is updated.
REQ-014 overrun  out  1  sticky flag; clk_en arrived while busy.

Function
REQ-015 The block SHALL time-share a single integrator datapath across the three populations via FSM states IDLE, UPD_L23, UPD_L4, UPD_L5, SUM.
REQ-016 In IDLE with clk_en=1 at edge N, it SHALL latch all three pyr inputs and enter UPD_L23; otherwise it SHALL remain in IDLE.
REQ-017 Edge N+1 SHALL update pv_l23; N+2 pv_l4; N+3 pv_l5; N+4 pv_total_inhibition; done SHALL be high exactly for the cycle following edge N+4; the FSM SHALL then be in IDLE.
REQ-018 Update rule per population: drive = |pyr| saturated to 2^(WIDTH-1)-1 (most-negative input maps to max positive); pv <= pv + ((drive - pv) >>> TAU_SHIFT), with the difference computed in WIDTH+1 bits and arithmetic shift.
REQ-019 The result SHALL stay within 0..2^(WIDTH-1)-1; clamp on any out-of-range value.
REQ-020 Total = pv_l23 + (pv_l4 >>> 1) + (pv_l5 >>> 2), computed in WIDTH+2 bits and saturated to 2^(WIDTH-1)-1.
REQ-021 Inputs SHALL be used only as latched at edge N; input changes during a round SHALL have no effect.
REQ-022 clk_en sampled in any non-IDLE state SHALL be ignored (no queueing) and SHALL set overrun; overrun clears only on rst.
REQ-023 Outputs SHALL hold their values between rounds.

Reset
REQ-024 On rst: state IDLE; all three pv outputs, pv_total_inhibition, busy, done and overrun = 0; applies mid-round with no done pulse and no partial update retained.
REQ-025 clk_en coincident with rst SHALL be ignored.

Configuration
REQ-026 Macro PV_L5_FEEDBACK_EN: when defined, behaviour is as above.
REQ-027 When undefined: UPD_L5 SHALL be skipped (UPD_L4 -> SUM); pv_l5_inhibition SHALL be held at 0; the total SHALL exclude the L5 term; done SHALL follow edge N+3.

Verification
REQ-028 Reset then idle 20 cycles -> all outputs 0, done never asserted.
REQ-029 TAU_SHIFT=3, pyr_l23=8192, others 0, two ticks spaced 10 cycles -> pv_l23 1024 then 1920; pv_total 1024 then 1920; done exactly 4 cycles after each tick.
REQ-030 All pyr=8192, one tick -> each pv 1024, pv_total 1792 (1536 with PV_L5_FEEDBACK_EN undefined, pv_l5 0, done after 3 cycles).
REQ-031 pyr_l4=-8192 vs +8192, and pyr_l23=-131072 -> identical pv_l4; pv_l23 treats -131072 as drive 131071.
REQ-032 All pyr=131071, 200 ticks -> pv values converge to at most 131071, pv_total saturates at 131071, no sign flip.
REQ-033 clk_en on two consecutive cycles -> one round only, overrun=1 until rst; rst asserted at the UPD_L4 edge -> all 0, no done.
